// File: rtl/hand_datapath.sv
// Baccarat hand datapath: six card registers, mod-10 hand scoring and
// active-low seven-segment display drive for each card slot.

module hand_card_slot (
   input  logic       slow_clock,
   input  logic       resetb,
   input  logic       load,
   input  logic       card_ok,
   input  logic [3:0] new_card,
   output logic [3:0] card,
   output logic [3:0] val,
   output logic [6:0] seg
);

   // Invalid cards are never stored, so the register only ever holds 0..13.
   always_ff @(posedge slow_clock or negedge resetb) begin
      if (!resetb)
         card <= 4'd0;
      else if (load && card_ok)
         card <= new_card;
   end

   // Pips count face value; 10, J, Q, K and empty all score zero.
   always_comb begin
      val = 4'd0;
      if (card >= 4'd1 && card <= 4'd9)
         val = card;
   end

   always_comb begin
      seg = 7'b1111111;
      case (card)
         4'd1:    seg = 7'b0001000;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         4'd10:   seg = 7'b1000000;
         4'd11:   seg = 7'b1100001;
         4'd12:   seg = 7'b0011000;
         4'd13:   seg = 7'b0001001;
         default: seg = 7'b1111111;
      endcase
   end

endmodule

module hand_score (
   input  logic [3:0] v0,
   input  logic [3:0] v1,
   input  logic [3:0] v2,
   output logic [3:0] score
);

   logic [4:0] sum;
   logic [4:0] red;

   // Max sum is 27, so one conditional subtraction of 10 or 20 suffices.
   always_comb begin
      sum = {1'b0, v0} + {1'b0, v1} + {1'b0, v2};
      red = sum;
      if (sum >= 5'd20)
         red = sum - 5'd20;
      else if (sum >= 5'd10)
         red = sum - 5'd10;
      score = red[3:0];
   end

endmodule

module hand_datapath (
   input  logic       slow_clock,
   input  logic       resetb,
   input  logic [3:0] new_card,
   input  logic       load_pcard1,
   input  logic       load_pcard2,
   input  logic       load_pcard3,
   input  logic       load_dcard1,
   input  logic       load_dcard2,
   input  logic       load_dcard3,
   output logic [3:0] pcard3_out,
   output logic [3:0] pscore_out,
   output logic [3:0] dscore_out,
   output logic       bad_card,
   output logic [6:0] HEX0,
   output logic [6:0] HEX1,
   output logic [6:0] HEX2,
   output logic [6:0] HEX3,
   output logic [6:0] HEX4,
   output logic [6:0] HEX5
);

   localparam int NUM_CARDS = 6;

   logic [NUM_CARDS-1:0]      load;
   logic [NUM_CARDS-1:0][3:0] card;
   logic [NUM_CARDS-1:0][3:0] val;
   logic [NUM_CARDS-1:0][6:0] seg;
   logic                      card_ok;

   // Slots 0..2 are player cards 1..3, slots 3..5 dealer cards 1..3.
   assign load    = {load_dcard3, load_dcard2, load_dcard1,
                     load_pcard3, load_pcard2, load_pcard1};
   assign card_ok = (new_card >= 4'd1) && (new_card <= 4'd13);

   genvar i;
   generate
      for (i = 0; i < NUM_CARDS; i++) begin : g_slot
         hand_card_slot u_slot (
            .slow_clock (slow_clock),
            .resetb     (resetb),
            .load       (load[i]),
            .card_ok    (card_ok),
            .new_card   (new_card),
            .card       (card[i]),
            .val        (val[i]),
            .seg        (seg[i])
         );
      end
   endgenerate

   always_ff @(posedge slow_clock or negedge resetb) begin
      if (!resetb)
         bad_card <= 1'b0;
      else if ((|load) && !card_ok)
         bad_card <= 1'b1;
   end

   hand_score u_pscore (.v0(val[0]), .v1(val[1]), .v2(val[2]), .score(pscore_out));
   hand_score u_dscore (.v0(val[3]), .v1(val[4]), .v2(val[5]), .score(dscore_out));

   assign pcard3_out = card[2];
   assign HEX0       = seg[0];
   assign HEX1       = seg[1];
   assign HEX2       = seg[2];
   assign HEX3       = seg[3];
   assign HEX4       = seg[4];
   assign HEX5       = seg[5];

endmodule

// File: tb/tb_hand_datapath.sv
// Directed bench for hand_datapath: reset, dealing, face cards, invalid
// cards, simultaneous strobes and asynchronous mid-round reset.

module tb_hand_datapath;

   logic       slow_clock = 1'b0;
   logic       resetb;
   logic [3:0] new_card;
   logic       load_pcard1, load_pcard2, load_pcard3;
   logic       load_dcard1, load_dcard2, load_dcard3;
   logic [3:0] pcard3_out, pscore_out, dscore_out;
   logic       bad_card;
   logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

   int checks   = 0;
   int failures = 0;

   localparam logic [6:0] BLANK = 7'b1111111;

   always #5 slow_clock = ~slow_clock;

   hand_datapath dut (
      .slow_clock (slow_clock),
      .resetb     (resetb),
      .new_card   (new_card),
      .load_pcard1(load_pcard1),
      .load_pcard2(load_pcard2),
      .load_pcard3(load_pcard3),
      .load_dcard1(load_dcard1),
      .load_dcard2(load_dcard2),
      .load_dcard3(load_dcard3),
      .pcard3_out (pcard3_out),
      .pscore_out (pscore_out),
      .dscore_out (dscore_out),
      .bad_card   (bad_card),
      .HEX0       (HEX0),
      .HEX1       (HEX1),
      .HEX2       (HEX2),
      .HEX3       (HEX3),
      .HEX4       (HEX4),
      .HEX5       (HEX5)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // strobe bits: [0]=p1 [1]=p2 [2]=p3 [3]=d1 [4]=d2 [5]=d3
   task automatic set_strobes(input logic [5:0] s);
      {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1} = s;
   endtask

   task automatic deal(input logic [5:0] s, input logic [3:0] c);
      @(negedge slow_clock);
      new_card = c;
      set_strobes(s);
      @(posedge slow_clock);
      #1;
      set_strobes(6'b0);
      new_card = 4'd0;
   endtask

   task automatic do_reset();
      @(negedge slow_clock);
      resetb = 1'b0;
      @(negedge slow_clock);
      resetb = 1'b1;
   endtask

   initial begin
      resetb   = 1'b0;
      new_card = 4'd0;
      set_strobes(6'b0);
      #2;
      check("rst_pscore", pscore_out, 0);
      check("rst_dscore", dscore_out, 0);
      check("rst_pcard3", pcard3_out, 0);
      check("rst_bad", bad_card, 0);
      check("rst_hex", {HEX0, HEX1, HEX2, HEX3, HEX4, HEX5}, {6{BLANK}});
      @(negedge slow_clock);
      resetb = 1'b1;
      repeat (3) @(posedge slow_clock);
      #1;
      check("idle_pscore", pscore_out, 0);
      check("idle_hex0", HEX0, BLANK);

      // normal deal
      deal(6'b000001, 4'd9);
      check("p1_9_pscore", pscore_out, 9);
      check("p1_9_hex0", HEX0, 7'b0010000);
      deal(6'b001000, 4'd13);
      check("d1_k_dscore", dscore_out, 0);
      check("d1_k_hex3", HEX3, 7'b0001001);
      deal(6'b000010, 4'd8);
      check("p2_8_pscore", pscore_out, 7);
      check("p2_8_hex1", HEX1, 7'b0000000);
      // strobe and card presented, but no edge yet: outputs must not move
      @(negedge slow_clock);
      new_card = 4'd5;
      set_strobes(6'b010000);
      #1;
      check("no_comb_dscore", dscore_out, 0);
      check("no_comb_hex4", HEX4, BLANK);
      @(posedge slow_clock);
      #1;
      set_strobes(6'b0);
      check("d2_5_dscore", dscore_out, 5);
      check("d2_5_hex4", HEX4, 7'b0010010);
      check("deal_pscore", pscore_out, 7);
      check("deal_bad", bad_card, 0);

      // face cards and third-card wrap
      do_reset();
      deal(6'b000001, 4'd12);
      check("p1_q_hex0", HEX0, 7'b0011000);
      deal(6'b000010, 4'd11);
      check("face_pscore", pscore_out, 0);
      check("p2_j_hex1", HEX1, 7'b1100001);
      deal(6'b000100, 4'd10);
      check("p3_10_pscore", pscore_out, 0);
      check("p3_10_pcard3", pcard3_out, 10);
      check("p3_10_hex2", HEX2, 7'b1000000);
      deal(6'b000100, 4'd7);
      check("p3_7_pscore", pscore_out, 7);
      check("p3_7_pcard3", pcard3_out, 7);
      check("p3_7_hex2", HEX2, 7'b1111000);

      // invalid cards
      do_reset();
      deal(6'b100000, 4'd3);
      check("d3_3_dscore", dscore_out, 3);
      deal(6'b100000, 4'd15);
      check("bad15_dscore", dscore_out, 3);
      check("bad15_hex5", HEX5, 7'b0110000);
      check("bad15_flag", bad_card, 1);
      deal(6'b010000, 4'd2);
      check("bad_sticky_dscore", dscore_out, 5);
      check("bad_sticky_flag", bad_card, 1);
      do_reset();
      check("bad_cleared", bad_card, 0);
      deal(6'b000001, 4'd0);
      check("bad0_flag", bad_card, 1);
      check("bad0_hex0", HEX0, BLANK);
      do_reset();
      deal(6'b000001, 4'd6);
      deal(6'b000001, 4'd14);
      check("bad14_pscore", pscore_out, 6);
      check("bad14_flag", bad_card, 1);
      // invalid card with no strobe must not flag
      do_reset();
      @(negedge slow_clock);
      new_card = 4'd15;
      @(posedge slow_clock);
      #1;
      new_card = 4'd0;
      check("nostrobe_bad", bad_card, 0);

      // simultaneous strobes
      deal(6'b001001, 4'd4);
      check("sim_pscore", pscore_out, 4);
      check("sim_dscore", dscore_out, 4);
      check("sim_hex", {HEX0, HEX3}, {7'b0011001, 7'b0011001});

      // mid-round asynchronous reset
      do_reset();
      deal(6'b000001, 4'd9);
      deal(6'b000010, 4'd9);
      deal(6'b000100, 4'd9);
      check("p999_pscore", pscore_out, 7);
      #2;
      resetb = 1'b0;
      #1;
      check("async_pscore", pscore_out, 0);
      check("async_hex", {HEX0, HEX1, HEX2}, {3{BLANK}});
      check("async_pcard3", pcard3_out, 0);
      // load during reset: reset wins
      @(negedge slow_clock);
      new_card = 4'd5;
      set_strobes(6'b001000);
      @(posedge slow_clock);
      #1;
      set_strobes(6'b0);
      check("rst_wins_dscore", dscore_out, 0);
      resetb = 1'b1;
      // first edge after release takes the load
      deal(6'b001000, 4'd5);
      check("post_rel_dscore", dscore_out, 5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
